// File: rtl/piso_seq_feeder.sv
// Parallel-in, serial-out streamer feeding a single-bit sequence-detector input.
// Words enter over valid/ready, leave MSB-first; a one-word buffer keeps streams gapless.
module piso_seq_feeder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] buf_reg_q, buf_reg_d;
  logic             buf_full_q, buf_full_d;
  logic             accept;

  // Output decode straight from the state registers
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid & shift_reg_q[WIDTH-1];
  assign ser_last   = ser_valid & (bit_cnt_q == CW'(WIDTH-1));
  assign busy       = ser_valid | buf_full_q;
  assign load_ready = ~buf_full_q & ~reset;
  assign accept     = load_valid & load_ready;

  // Next-state: direct load, buffered load, bit advance and word hand-over
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    buf_reg_d   = buf_reg_q;
    buf_full_d  = buf_full_q;

    if (state_q == IDLE) begin
      if (accept) begin
        shift_reg_d = load_data;
        bit_cnt_d   = '0;
        state_d     = SHIFT;
      end
    end else if (shift_en && ser_last) begin
      // A full buffer forces load_ready low, so accept cannot coincide with it
      if (buf_full_q) begin
        shift_reg_d = buf_reg_q;
        bit_cnt_d   = '0;
        buf_full_d  = 1'b0;
      end else if (accept) begin
        shift_reg_d = load_data;
        bit_cnt_d   = '0;
      end else begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    end else begin
      if (shift_en) begin
        shift_reg_d = {shift_reg_q[WIDTH-2:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + CW'(1);
      end
      if (accept) begin
        buf_reg_d  = load_data;
        buf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
      buf_reg_q   <= '0;
      buf_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      buf_reg_q   <= buf_reg_d;
      buf_full_q  <= buf_full_d;
    end
  end

endmodule

// File: tb/tb_piso_seq_feeder.sv
// Bench for piso_seq_feeder: directed scenarios plus random traffic checked
// every cycle against a bit-queue model of the word stream.
module tb_piso_seq_feeder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         shift_en;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Model: bits still to send of the current word, plus an optional waiting word
  bit           cur_q[$];
  logic [W-1:0] buf_w;
  bit           buf_has;

  // Per-scenario observations
  logic [63:0] cap;
  int          ncap;
  int          nvalid;
  int          nlast;
  int          nready_low;

  piso_seq_feeder #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev, eo, el, er, eb;
    ev = !reset && (cur_q.size() > 0);
    eo = ev && cur_q[0];
    el = ev && (cur_q.size() == 1);
    er = !reset && !buf_has;
    eb = !reset && (ev || buf_has);
    check("ser_valid",  32'(ser_valid),  32'(ev));
    check("ser_out",    32'(ser_out),    32'(eo));
    check("ser_last",   32'(ser_last),   32'(el));
    check("load_ready", 32'(load_ready), 32'(er));
    check("busy",       32'(busy),       32'(eb));
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) cur_q.push_back(w[i]);
  endtask

  task automatic model_update(input logic rst, input logic lv, input logic [W-1:0] d,
                              input logic en);
    bit acc;
    if (rst) begin
      cur_q.delete();
      buf_has = 1'b0;
      return;
    end
    acc = lv && !buf_has;
    if (cur_q.size() > 0 && en) void'(cur_q.pop_front());
    if (cur_q.size() == 0 && buf_has) begin
      push_word(buf_w);
      buf_has = 1'b0;
    end
    if (acc) begin
      if (cur_q.size() == 0) push_word(d);
      else begin
        buf_w   = d;
        buf_has = 1'b1;
      end
    end
  endtask

  task automatic clear_stats();
    cap = '0; ncap = 0; nvalid = 0; nlast = 0; nready_low = 0;
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge
  task automatic cycle(input logic rst, input logic lv, input logic [W-1:0] d, input logic en);
    reset = rst; load_valid = lv; load_data = d; shift_en = en;
    #1;
    check_outputs();
    if (ser_valid && en) begin
      cap = {cap[62:0], ser_out};
      ncap++;
    end
    if (ser_valid) nvalid++;
    if (ser_last) nlast++;
    if (!load_ready) nready_low++;
    @(posedge clk);
    model_update(rst, lv, d, en);
    @(negedge clk);
  endtask

  function automatic int count_01(input logic [63:0] c, input int n);
    int k = 0;
    for (int j = 0; j < n - 1; j++)
      if (c[n-1-j] == 1'b0 && c[n-2-j] == 1'b1) k++;
    return k;
  endfunction

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; shift_en = 1'b0;
    buf_has = 1'b0; buf_w = '0;
    clear_stats();
    @(negedge clk);

    // Reset for 20 ns, then idle
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1);

    // Single word 0101_1001
    cycle(0, 1, 8'b0101_1001, 1);
    clear_stats();
    for (int i = 0; i < 9; i++) cycle(0, 0, '0, 1);
    check("single_bits",  32'(cap[7:0]), 32'h59);
    check("single_count", 32'(ncap),     32'd8);
    check("single_last",  32'(nlast),    32'd1);
    check("single_valid", 32'(nvalid),   32'd8);
    check("detect_01",    32'(count_01(cap, 8)), 32'd3);

    // Back-to-back A5, 3C
    clear_stats();
    cycle(0, 1, 8'hA5, 1);
    cycle(0, 1, 8'h3C, 1);
    for (int i = 0; i < 17; i++) cycle(0, 0, '0, 1);
    check("b2b_bits",      32'(cap[15:0]),  32'hA53C);
    check("b2b_valid",     32'(nvalid),     32'd16);
    check("b2b_ready_low", 32'(nready_low), 32'd7);

    // Pause during F0 after two bits
    clear_stats();
    cycle(0, 1, 8'hF0, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, '0, 1);
    check("pause_bits",  32'(cap[7:0]), 32'hF0);
    check("pause_valid", 32'(nvalid),   32'd11);

    // Buffer full: third word must be dropped
    clear_stats();
    cycle(0, 1, 8'hC3, 1);
    cycle(0, 1, 8'h5A, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'hFF, 1);
    for (int i = 0; i < 15; i++) cycle(0, 0, '0, 1);
    check("full_bits",  32'(cap[15:0]), 32'hC35A);
    check("full_count", 32'(ncap),      32'd16);
    check("full_idle",  32'(busy),      32'd0);

    // Asynchronous reset mid-word with a buffered word pending
    cycle(0, 1, 8'hFF, 1);
    cycle(0, 1, 8'h77, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    reset = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(0, 0, '0, 1);
    #2;
    check("pre_rst_valid", 32'(ser_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("async_valid", 32'(ser_valid),  32'd0);
    check("async_out",   32'(ser_out),    32'd0);
    check("async_ready", 32'(load_ready), 32'd0);
    check("async_busy",  32'(busy),       32'd0);
    model_update(1, 0, '0, 1);
    @(negedge clk);
    cycle(1, 0, '0, 1);
    cycle(0, 0, '0, 1);
    cycle(0, 1, 8'h01, 1);
    clear_stats();
    for (int i = 0; i < 9; i++) cycle(0, 0, '0, 1);
    check("post_rst_bits",  32'(cap[7:0]), 32'h01);
    check("post_rst_count", 32'(ncap),     32'd8);

    // Continuous valid at full rate
    clear_stats();
    for (int i = 0; i < 40; i++) cycle(0, 1, W'($urandom), 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);
    check("stream_gapless", 32'(nvalid), 32'(ncap));

    // Random traffic with occasional pauses and resets
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 149) == 0), 1'($urandom), W'($urandom),
            ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_seq_feeder.md
Name: piso_seq_feeder

Overview:
- Parallel-in, serial-out bit streamer that sits directly upstream of the sequence-detector FSMs and drives their single-bit input (A) one bit per clock.
- Accepts WIDTH-bit words through a valid/ready handshake and emits each word MSB-first.
- One-word holding buffer, so back-to-back words stream with no idle cycles.
- Optional pause input freezes the stream for bench or downstream throttling.

Parameters:
- WIDTH, 8, bits per word; legal range 2 to 32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- load_valid  input  1  upstream presents load_data this cycle.
- load_data  input  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  1 = advance one bit per clock; 0 = hold current bit.
- ser_out  output  1  serial bit, connects to detector input A; 0 whenever ser_valid=0.
- ser_valid  output  1  ser_out carries a live bit.
- ser_last  output  1  current bit is bit 0 (last) of its word.
- busy  output  1  shifter active or buffer occupied.

Behaviour:
- State: state{IDLE,SHIFT}, shift_reg[WIDTH], bit_cnt[CW], buf_reg[WIDTH], buf_full.
- Reset (async, any time, including mid-word): state=IDLE, shift_reg=0, bit_cnt=0, buf_reg=0, buf_full=0.
  - Outputs during and after reset: ser_out=0, ser_valid=0, ser_last=0, busy=0.
  - load_ready=0 while reset is high and 1 from the first cycle after release.
  - A partially sent word is discarded, not resumed.
- load_ready = ~buf_full & ~reset (combinational). accept = load_valid & load_ready.
- Output decode: ser_valid = (state==SHIFT); ser_out = ser_valid & shift_reg[WIDTH-1]; ser_last = ser_valid & (bit_cnt==WIDTH-1); busy = ser_valid | buf_full.
- Direct load:
  - Condition: accept in IDLE, or accept on an edge where the current last bit is consumed (ser_last & shift_en) with buf_full=0.
  - Action: shift_reg<=load_data, bit_cnt<=0, state<=SHIFT.
  - Latency: first bit appears on ser_out the cycle after the accept edge.
- Buffered load: accept in SHIFT that is not the last-bit-consume case -> buf_reg<=load_data, buf_full<=1.
- Bit advance (SHIFT & shift_en, not last bit): shift_reg<=shift_reg<<1 (LSB fill 0), bit_cnt<=bit_cnt+1.
- Last bit consumed (SHIFT & shift_en & ser_last):
  - buf_full=1: shift_reg<=buf_reg, bit_cnt<=0, buf_full<=0, stay SHIFT (gapless).
  - buf_full=0 with accept: direct load (gapless).
  - Otherwise: state<=IDLE, bit_cnt<=0.
- shift_en=0:
  - shift_reg, bit_cnt and state hold; ser_out and ser_valid stay constant.
  - Accepts into an empty buffer still occur.
  - In IDLE a direct load still occurs; the first bit is then held until shift_en rises.
- Buffer full: load_ready=0; load_valid is ignored and the word is not captured. Upstream must hold data and valid.
- Throughput: one bit per enabled clock; WIDTH cycles per word; sustained at full rate with continuous valid.

Test Plan:
- Reset then idle: reset=1 for 20 ns, release, load_valid=0 -> ser_valid=0, ser_out=0, load_ready=1, busy=0 for 10 cycles.
- Single word 8'b0101_1001 with shift_en=1 -> ser_out over the next 8 cycles = 0,1,0,1,1,0,0,1. ser_last only in cycle 8. Downstream "01" Moore detector Y pulses 3 times. ser_valid drops in cycle 9.
- Back-to-back 8'hA5 then 8'h3C, valid held high -> second word accepted into buffer (load_ready drops to 0 for 7 cycles). 16 consecutive bits 10100101 00111100 with no ser_valid gap.
- Pause: during word 8'hF0, drop shift_en for 3 cycles after bit 2 -> ser_out holds 1 for those cycles. Stream resumes with the remaining 1,1,0,0,0,0. Total ser_valid duration = 11 cycles.
- Buffer full: word in flight plus buffered word, third load_valid pulse -> load_ready=0, third word not captured; output is exactly the 16 bits of the first two words.
- Mid-word reset: assert reset async mid-cycle after bit 4 of 8'hFF -> ser_valid/ser_out fall immediately without waiting for clk, buffer is cleared. After release, load_ready=1 and a new word 8'h01 streams cleanly (7 zeros, then 1).
